decrypt_run_controller: RTL

//  Top-level run sequencer for the decryption processor wrapper: drives cpu_en/wrstate/curr_index/char_buffer_data
//  to stream a ciphertext buffer into RAM at 1500+, pulses processor reset, runs EN or BF program until the
//  reg28 done flag fires, then drives read_addr to stream the result bytes back out. Sits between host byte link and Wrapper.

---
 rtl/decrypt_run_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/decrypt_run_controller.sv
// decrypt_run_controller: streams a ciphertext buffer into RAM, resets and runs the processor, then reads results back.
// Define WATCHDOG_EN to add an EXEC timeout that forces ERR after TIMEOUT_CYCLES without done_flag.
module decrypt_run_controller #(
  parameter int          BUF_LEN        = 108,
  parameter logic [11:0] RESULT_BASE    = 12'd1500,
  parameter int          RESULT_LEN     = 108,
  parameter int          CPU_RST_CYCLES = 4,
  parameter int          TIMEOUT_CYCLES = 2**24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode_sel,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [1:0]  cpu_en,
  output logic        cpu_reset,
  output logic [1:0]  program_sel,
  output logic [7:0]  char_buffer_data,
  output logic [7:0]  curr_index,
  output logic [1:0]  wrstate,
  output logic [11:0] read_addr,
  input  logic [31:0] read_data,
  input  logic        done_flag,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CPURST, S_EXEC, S_RD_ADDR, S_RD_CAP, S_RD_OUT, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        full_q, full_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [11:0] k_q, k_d;
  logic [1:0]  program_sel_q, program_sel_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  curr_index_q, curr_index_d;
  logic [1:0]  wrstate_q, wrstate_d;
  logic [11:0] read_addr_q, read_addr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        error_q, error_d;
`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  logic mode_ok;
  logic unused_read_data;
  assign mode_ok          = (mode_sel == 2'b01) || (mode_sel == 2'b10);
  assign unused_read_data = ^read_data[31:8];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    full_d        = full_q;
    rst_cnt_d     = rst_cnt_q;
    k_d           = k_q;
    program_sel_d = program_sel_q;
    char_d        = char_q;
    curr_index_d  = curr_index_q;
    wrstate_d     = 2'b00;
    read_addr_d   = read_addr_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    error_d       = error_q;
`ifdef WATCHDOG_EN
    wd_d          = wd_q;
`endif
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start && mode_ok) begin
          state_d       = S_LOAD;
          program_sel_d = mode_sel;
          idx_d         = 8'd0;
          full_d        = 1'b0;
          error_d       = 1'b0;
        end else if (start) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      S_LOAD: begin
        // full_q holds LOAD one extra cycle so the last commit pulse still sees cpu_en=01
        if (full_q) begin
          state_d   = S_CPURST;
          rst_cnt_d = 8'd0;
        end else if (in_valid) begin
          char_d       = in_data;
          curr_index_d = idx_q;
          wrstate_d    = 2'b10;
          if (idx_q == 8'(BUF_LEN - 1)) full_d = 1'b1;
          else                          idx_d  = idx_q + 8'd1;
        end
      end
      S_CPURST: begin
        if (rst_cnt_q == 8'(CPU_RST_CYCLES - 1)) begin
          state_d = S_EXEC;
`ifdef WATCHDOG_EN
          wd_d    = '0;
`endif
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (done_flag) begin
          state_d     = S_RD_ADDR;
          read_addr_d = RESULT_BASE;
          k_d         = 12'd0;
        end
`ifdef WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        out_data_d  = read_data[7:0];
        out_valid_d = 1'b1;
        state_d     = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (k_q == 12'(RESULT_LEN - 1)) begin
            state_d = S_DONE;
          end else begin
            k_d         = k_q + 12'd1;
            read_addr_d = read_addr_q + 12'd1;
            state_d     = S_RD_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 8'd0;
      full_q        <= 1'b0;
      rst_cnt_q     <= 8'd0;
      k_q           <= 12'd0;
      program_sel_q <= 2'b00;
      char_q        <= 8'd0;
      curr_index_q  <= 8'd0;
      wrstate_q     <= 2'b00;
      read_addr_q   <= 12'd0;
      out_data_q    <= 8'd0;
      out_valid_q   <= 1'b0;
      error_q       <= 1'b0;
`ifdef WATCHDOG_EN
      wd_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      full_q        <= full_d;
      rst_cnt_q     <= rst_cnt_d;
      k_q           <= k_d;
      program_sel_q <= program_sel_d;
      char_q        <= char_d;
      curr_index_q  <= curr_index_d;
      wrstate_q     <= wrstate_d;
      read_addr_q   <= read_addr_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      error_q       <= error_d;
`ifdef WATCHDOG_EN
      wd_q          <= wd_d;
`endif
    end
  end

  assign in_ready         = (state_q == S_LOAD) && !full_q;
  assign cpu_en           = (state_q == S_LOAD) ? 2'b01 :
                            ((state_q == S_CPURST) || (state_q == S_EXEC)) ? 2'b10 : 2'b00;
  assign cpu_reset        = !((state_q == S_EXEC) || (state_q == S_RD_ADDR) ||
                              (state_q == S_RD_CAP) || (state_q == S_RD_OUT));
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign program_sel      = program_sel_q;
  assign char_buffer_data = char_q;
  assign curr_index       = curr_index_q;
  assign wrstate          = wrstate_q;
  assign read_addr        = read_addr_q;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign error            = error_q;

endmodule
